// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter driving the select (S) and enable (EN) of a shared 4:1 mux.
// Optional macro MUX_ARB_PREEMPT_EN: requester 0 preempts any other owner.
module mux_4_1_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] S,
  output logic       EN
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      gnt_reg, gnt_next;
  logic [1:0]      sel_reg, sel_next;
  logic [1:0]      last_reg, last_next;
  logic            en_reg, en_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic [3:0]      others;
  logic [1:0]      win;
  logic            take;

  // First set bit of cand in the order from+1, from+2, from+3, from (2-bit wrap).
  function automatic logic [1:0] rr_pick(input logic [3:0] cand, input logic [1:0] from);
    logic [1:0] idx;
    rr_pick = from;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (cand[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    en_next    = en_reg;
    cnt_next   = cnt_reg;
    others     = REQ & ~(4'b0001 << sel_reg);
    win        = rr_pick(REQ, last_reg);
    take       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (|REQ) take = 1'b1;
      end
      GRANT: begin
`ifdef MUX_ARB_PREEMPT_EN
        if (REQ[0] && sel_reg != 2'd0) begin
          take      = 1'b1;
          win       = 2'd0;
          last_next = sel_reg;
        end else
`endif
        if (!REQ[sel_reg]) begin
          last_next = sel_reg;
          if (|others) begin
            take = 1'b1;
            win  = rr_pick(others, sel_reg);
          end else begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
            en_next    = 1'b0;
          end
        end else if (MAX_HOLD != 0 && cnt_reg == CNT_MAX) begin
          // Saturate while alone; rotate away only when someone else waits.
          if (|others) begin
            take      = 1'b1;
            last_next = sel_reg;
            win       = rr_pick(others, sel_reg);
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (take) begin
      state_next = GRANT;
      sel_next   = win;
      gnt_next   = 4'b0001 << win;
      en_next    = 1'b1;
      cnt_next   = CNT_ONE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      gnt_reg   <= 4'b0000;
      sel_reg   <= 2'd0;
      last_reg  <= 2'd3;
      en_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      en_reg    <= en_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign GNT = gnt_reg;
  assign S   = sel_reg;
  assign EN  = en_reg;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Bench for mux_4_1_rr_arbiter: MAX_HOLD=4 and MAX_HOLD=0 instances share stimulus
// and are checked every cycle against a behavioural ownership model.
module tb_mux_4_1_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt_o [2];
  logic [1:0] s_o   [2];
  logic       en_o  [2];

  int n_run;
  int n_fail;
  int cyc;

  // Model: owner index (-1 = idle), last owner, cycles held, visible select.
  int hold_cfg [2];
  int m_owner  [2];
  int m_last   [2];
  int m_held   [2];
  int m_sel    [2];

  mux_4_1_rr_arbiter #(.MAX_HOLD(4)) dut_h4 (
    .CLK(clk), .RST(rst), .REQ(req), .GNT(gnt_o[0]), .S(s_o[0]), .EN(en_o[0])
  );
  mux_4_1_rr_arbiter #(.MAX_HOLD(0)) dut_h0 (
    .CLK(clk), .RST(rst), .REQ(req), .GNT(gnt_o[1]), .S(s_o[1]), .EN(en_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_after(input logic [3:0] cand, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (cand[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset(input int i);
    m_owner[i] = -1;
    m_last[i]  = 3;
    m_held[i]  = 0;
    m_sel[i]   = 0;
  endtask

  task automatic model_give(input int i, input int w);
    m_owner[i] = w;
    m_sel[i]   = w;
    m_held[i]  = 1;
  endtask

  task automatic model_step(input int i, input logic [3:0] r);
    int o;
    logic [3:0] rest;
    o = m_owner[i];
    if (o < 0) begin
      if (r != 4'b0) model_give(i, first_after(r, m_last[i]));
      return;
    end
    rest = r;
    rest[o] = 1'b0;
`ifdef MUX_ARB_PREEMPT_EN
    if (r[0] && o != 0) begin
      m_last[i] = o;
      model_give(i, 0);
      return;
    end
`endif
    if (!r[o]) begin
      m_last[i] = o;
      if (rest != 4'b0) model_give(i, first_after(rest, o));
      else m_owner[i] = -1;
    end else if (hold_cfg[i] != 0 && m_held[i] >= hold_cfg[i]) begin
      if (rest != 4'b0) begin
        m_last[i] = o;
        model_give(i, first_after(rest, o));
      end
    end else begin
      m_held[i]++;
    end
  endtask

  function automatic logic [6:0] exp_vec(input int i);
    logic [3:0] g;
    g = 4'b0;
    if (m_owner[i] >= 0) g[m_owner[i]] = 1'b1;
    return {g, 2'(m_sel[i]), (m_owner[i] >= 0)};
  endfunction

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) model_reset(i);
      else model_step(i, r);
    end
    #1;
    cyc++;
    $display("[TB] cyc %0d rst=%b req=%b | h4 gnt=%b s=%0d en=%b | h0 gnt=%b s=%0d en=%b",
             cyc, rst, r, gnt_o[0], s_o[0], en_o[0], gnt_o[1], s_o[1], en_o[1]);
  endtask

  task automatic test_reset;
    logic [6:0] w;
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 2; i++) model_reset(i);
    for (int c = 0; c < 3; c++) begin
      step(4'b1111);
      for (int i = 0; i < 2; i++) begin
        n_run++;
        if ({gnt_o[i], s_o[i], en_o[i]} !== 7'b0) begin
          n_fail++;
          $display("FAIL reset_hold[%0d] got gnt=%b s=%0d en=%b want all zero", i, gnt_o[i], s_o[i], en_o[i]);
        end
      end
    end
    #3 rst = 1'b0;
    step(4'b1111);
    for (int i = 0; i < 2; i++) begin
      w = exp_vec(i);
      n_run++;
      if ({gnt_o[i], s_o[i], en_o[i]} !== w || gnt_o[i] !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset_release[%0d] got gnt=%b s=%0d en=%b want gnt=%b s=%0d en=%b",
                 i, gnt_o[i], s_o[i], en_o[i], w[6:3], w[2:1], w[0]);
      end
    end
  endtask

  task automatic test_single;
    logic [6:0] w;
    for (int c = 0; c < 11; c++) begin
      step((c < 10) ? 4'b0100 : 4'b0000);
      for (int i = 0; i < 2; i++) begin
        w = exp_vec(i);
        n_run++;
        if ({gnt_o[i], s_o[i], en_o[i]} !== w) begin
          n_fail++;
          $display("FAIL single[%0d] got gnt=%b s=%0d en=%b want gnt=%b s=%0d en=%b",
                   i, gnt_o[i], s_o[i], en_o[i], w[6:3], w[2:1], w[0]);
        end
      end
    end
    n_run++;
    if (s_o[0] !== 2'd2 || en_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release got s=%0d en=%b want s=2 en=0", s_o[0], en_o[0]);
    end
  endtask

  task automatic test_rotation;
    logic [6:0] w;
    int run_len;
    int prev;
    run_len = 0;
    prev = -1;
    for (int c = 0; c < 24; c++) begin
      step(4'b1111);
      for (int i = 0; i < 2; i++) begin
        w = exp_vec(i);
        n_run++;
        if ({gnt_o[i], s_o[i], en_o[i]} !== w) begin
          n_fail++;
          $display("FAIL rotation[%0d] got gnt=%b s=%0d en=%b want gnt=%b s=%0d en=%b",
                   i, gnt_o[i], s_o[i], en_o[i], w[6:3], w[2:1], w[0]);
        end
      end
      if (int'(s_o[0]) == prev) run_len++;
      else begin
        if (prev >= 0) begin
          n_run++;
          if (run_len != 4) begin
            n_fail++;
            $display("FAIL rotation_len owner %0d held %0d cycles want 4", prev, run_len);
          end
        end
        prev = int'(s_o[0]);
        run_len = 1;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] w;
    logic [3:0] pat [5];
    pat = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000};
    for (int c = 0; c < 5; c++) begin
      step(pat[c]);
      for (int i = 0; i < 2; i++) begin
        w = exp_vec(i);
        n_run++;
        if ({gnt_o[i], s_o[i], en_o[i]} !== w || (c >= 1 && en_o[i] !== 1'b1)) begin
          n_fail++;
          $display("FAIL handoff[%0d] got gnt=%b s=%0d en=%b want gnt=%b s=%0d en=%b",
                   i, gnt_o[i], s_o[i], en_o[i], w[6:3], w[2:1], w[0]);
        end
      end
    end
    n_run++;
    if (gnt_o[0] !== 4'b1000 || s_o[0] !== 2'd3) begin
      n_fail++;
      $display("FAIL handoff_target got gnt=%b s=%0d want gnt=1000 s=3", gnt_o[0], s_o[0]);
    end
  endtask

  task automatic test_unlimited;
    logic [6:0] w;
    for (int c = 0; c < 21; c++) begin
      step((c < 20) ? 4'b1001 : 4'b0001);
      for (int i = 0; i < 2; i++) begin
        w = exp_vec(i);
        n_run++;
        if ({gnt_o[i], s_o[i], en_o[i]} !== w) begin
          n_fail++;
          $display("FAIL unlimited[%0d] got gnt=%b s=%0d en=%b want gnt=%b s=%0d en=%b",
                   i, gnt_o[i], s_o[i], en_o[i], w[6:3], w[2:1], w[0]);
        end
      end
      if (c == 19) begin
        n_run++;
        if (gnt_o[1] !== 4'b1000) begin
          n_fail++;
          $display("FAIL unlimited_keep got gnt=%b want 1000", gnt_o[1]);
        end
      end
    end
    n_run++;
    if (gnt_o[1] !== 4'b0001) begin
      n_fail++;
      $display("FAIL unlimited_drop got gnt=%b want 0001", gnt_o[1]);
    end
  endtask

  task automatic test_async_reset;
    logic [6:0] w;
    step(4'b0000);
    step(4'b0100);
    step(4'b0100);
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) model_reset(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_run++;
      if ({gnt_o[i], s_o[i], en_o[i]} !== 7'b0) begin
        n_fail++;
        $display("FAIL async_reset[%0d] got gnt=%b s=%0d en=%b want all zero", i, gnt_o[i], s_o[i], en_o[i]);
      end
    end
    #2 rst = 1'b0;
    step(4'b0110);
    for (int i = 0; i < 2; i++) begin
      w = exp_vec(i);
      n_run++;
      if ({gnt_o[i], s_o[i], en_o[i]} !== w || gnt_o[i] !== 4'b0010) begin
        n_fail++;
        $display("FAIL async_release[%0d] got gnt=%b s=%0d en=%b want gnt=0010",
                 i, gnt_o[i], s_o[i], en_o[i]);
      end
    end
  endtask

`ifdef MUX_ARB_PREEMPT_EN
  task automatic test_preempt;
    step(4'b0000);
    step(4'b0100);
    step(4'b0101);
    for (int i = 0; i < 2; i++) begin
      n_run++;
      if (gnt_o[i] !== 4'b0001 || s_o[i] !== 2'd0) begin
        n_fail++;
        $display("FAIL preempt[%0d] got gnt=%b s=%0d want gnt=0001 s=0", i, gnt_o[i], s_o[i]);
      end
    end
  endtask
`endif

  task automatic test_random;
    logic [6:0] w;
    logic [3:0] r;
    r = 4'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 2) begin
        #1 rst = 1'b1;
        for (int i = 0; i < 2; i++) model_reset(i);
        #2 rst = 1'b0;
      end
      step(r);
      for (int i = 0; i < 2; i++) begin
        w = exp_vec(i);
        n_run++;
        if ({gnt_o[i], s_o[i], en_o[i]} !== w) begin
          n_fail++;
          $display("FAIL random[%0d] cyc %0d req=%b got gnt=%b s=%0d en=%b want gnt=%b s=%0d en=%b",
                   i, cyc, r, gnt_o[i], s_o[i], en_o[i], w[6:3], w[2:1], w[0]);
        end
      end
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    cyc = 0;
    hold_cfg[0] = 4;
    hold_cfg[1] = 0;
    rst = 1'b1;
    req = 4'b1111;
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_unlimited();
    test_async_reset();
`ifdef MUX_ARB_PREEMPT_EN
    test_preempt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
